// File: rtl/amber_ras_pkg.sv
// amber_ras_pkg: sizing constants shared by the return-address stack and the IA/ID stages
package amber_ras_pkg;
    localparam int RAS_ADDR_W = 24;
    localparam int RAS_DEPTH  = 8;
endpackage

// File: rtl/amber_ras_if.sv
// amber_ras_if: decode/retire/flush inputs and prediction outputs of the return-address stack
interface amber_ras_if
    import amber_ras_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int DEPTH  = RAS_DEPTH
);
    localparam int PTR_W = $clog2(DEPTH);
    logic              iw_spec_push;
    logic              iw_spec_pop;
    logic [ADDR_W-1:0] iw_spec_addr;
    logic              iw_cmt_push;
    logic              iw_cmt_pop;
    logic [ADDR_W-1:0] iw_cmt_addr;
    logic              iw_flush;
    logic              ow_top_valid;
    logic [ADDR_W-1:0] ow_top_addr;
    logic [PTR_W:0]    ow_spec_cnt;
    logic [PTR_W:0]    ow_cmt_cnt;
    logic              ow_ovf;
    modport master (
        output iw_spec_push, iw_spec_pop, iw_spec_addr,
        output iw_cmt_push, iw_cmt_pop, iw_cmt_addr, iw_flush,
        input  ow_top_valid, ow_top_addr, ow_spec_cnt, ow_cmt_cnt, ow_ovf
    );
    modport slave (
        input  iw_spec_push, iw_spec_pop, iw_spec_addr,
        input  iw_cmt_push, iw_cmt_pop, iw_cmt_addr, iw_flush,
        output ow_top_valid, ow_top_addr, ow_spec_cnt, ow_cmt_cnt, ow_ovf
    );
endinterface

// File: rtl/amber_ras_bank.sv
// amber_ras_bank: one circular return-address stack; exposes its next state so a twin can be loaded from it
module amber_ras_bank
    import amber_ras_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int DEPTH  = RAS_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic                         iw_clk,
    input  logic                         iw_rst_n,
    input  logic                         iw_push,
    input  logic                         iw_pop,
    input  logic [ADDR_W-1:0]            iw_addr,
    input  logic                         iw_load_en,
    input  logic [DEPTH-1:0][ADDR_W-1:0] iw_load_mem,
    input  logic [PTR_W-1:0]             iw_load_tos,
    input  logic [PTR_W:0]               iw_load_cnt,
    output logic [DEPTH-1:0][ADDR_W-1:0] ow_nxt_mem,
    output logic [PTR_W-1:0]             ow_nxt_tos,
    output logic [PTR_W:0]               ow_nxt_cnt,
    output logic                         ow_wrap
);
    localparam int CNT_W = PTR_W + 1;
    logic [DEPTH-1:0][ADDR_W-1:0] r_mem;
    logic [DEPTH-1:0][ADDR_W-1:0] w_mem_o;
    logic [PTR_W-1:0]             r_tos;
    logic [PTR_W-1:0]             w_tos_p;
    logic [PTR_W-1:0]             w_tos_o;
    logic [CNT_W-1:0]             r_cnt;
    logic [CNT_W-1:0]             w_cnt_p;
    logic [CNT_W-1:0]             w_cnt_o;
    logic                         w_pop_ok;
    logic                         w_full_p;

    // pop first, then push onto the popped state; a load replaces the whole result
    always_comb begin
        w_pop_ok   = iw_pop && (r_cnt != '0);
        w_tos_p    = w_pop_ok ? r_tos - PTR_W'(1) : r_tos;
        w_cnt_p    = w_pop_ok ? r_cnt - CNT_W'(1) : r_cnt;
        w_full_p   = w_cnt_p == CNT_W'(DEPTH);
        w_tos_o    = iw_push ? w_tos_p + PTR_W'(1) : w_tos_p;
        w_cnt_o    = (iw_push && !w_full_p) ? w_cnt_p + CNT_W'(1) : w_cnt_p;
        w_mem_o    = r_mem;
        if (iw_push)
            w_mem_o[w_tos_o] = iw_addr;
        ow_nxt_mem = iw_load_en ? iw_load_mem : w_mem_o;
        ow_nxt_tos = iw_load_en ? iw_load_tos : w_tos_o;
        ow_nxt_cnt = iw_load_en ? iw_load_cnt : w_cnt_o;
        ow_wrap    = iw_push && w_full_p && !iw_load_en;
    end

    // stack state register
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            r_mem <= '0;
            r_tos <= '0;
            r_cnt <= '0;
        end else begin
            r_mem <= ow_nxt_mem;
            r_tos <= ow_nxt_tos;
            r_cnt <= ow_nxt_cnt;
        end
    end
endmodule

// File: rtl/amber_ras.sv
// amber_ras: speculative + committed return-address stacks predicting RET targets for IA
module amber_ras
    import amber_ras_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int DEPTH  = RAS_DEPTH
) (
    input logic         iw_clk,
    input logic         iw_rst_n,
    amber_ras_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [DEPTH-1:0][ADDR_W-1:0] w_cmt_mem;
    logic [PTR_W-1:0]             w_cmt_tos;
    logic [PTR_W:0]               w_cmt_cnt;
    logic                         w_cmt_wrap_unused;
    logic [DEPTH-1:0][ADDR_W-1:0] w_spec_mem;
    logic [PTR_W-1:0]             w_spec_tos;
    logic [PTR_W:0]               w_spec_cnt;
    logic                         w_spec_wrap;
    logic                         r_top_valid;
    logic [ADDR_W-1:0]            r_top_addr;
    logic [PTR_W:0]               r_spec_cnt;
    logic [PTR_W:0]               r_cmt_cnt;
    logic                         r_ovf;

    amber_ras_bank #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_cmt (
        .iw_clk      (iw_clk),
        .iw_rst_n    (iw_rst_n),
        .iw_push     (bus.iw_cmt_push),
        .iw_pop      (bus.iw_cmt_pop),
        .iw_addr     (bus.iw_cmt_addr),
        .iw_load_en  (1'b0),
        .iw_load_mem ('0),
        .iw_load_tos ('0),
        .iw_load_cnt ('0),
        .ow_nxt_mem  (w_cmt_mem),
        .ow_nxt_tos  (w_cmt_tos),
        .ow_nxt_cnt  (w_cmt_cnt),
        .ow_wrap     (w_cmt_wrap_unused)
    );

    // flush reloads from the committed stack's post-retirement state, bypassing its register
    amber_ras_bank #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_spec (
        .iw_clk      (iw_clk),
        .iw_rst_n    (iw_rst_n),
        .iw_push     (bus.iw_spec_push),
        .iw_pop      (bus.iw_spec_pop),
        .iw_addr     (bus.iw_spec_addr),
        .iw_load_en  (bus.iw_flush),
        .iw_load_mem (w_cmt_mem),
        .iw_load_tos (w_cmt_tos),
        .iw_load_cnt (w_cmt_cnt),
        .ow_nxt_mem  (w_spec_mem),
        .ow_nxt_tos  (w_spec_tos),
        .ow_nxt_cnt  (w_spec_cnt),
        .ow_wrap     (w_spec_wrap)
    );

    // output registers track the banks' next state so they line up with the stack contents
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            r_top_valid <= 1'b0;
            r_top_addr  <= '0;
            r_spec_cnt  <= '0;
            r_cmt_cnt   <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_top_valid <= w_spec_cnt != '0;
            r_top_addr  <= (w_spec_cnt != '0) ? w_spec_mem[w_spec_tos] : '0;
            r_spec_cnt  <= w_spec_cnt;
            r_cmt_cnt   <= w_cmt_cnt;
            r_ovf       <= w_spec_wrap;
        end
    end

    assign bus.ow_top_valid = r_top_valid;
    assign bus.ow_top_addr  = r_top_addr;
    assign bus.ow_spec_cnt  = r_spec_cnt;
    assign bus.ow_cmt_cnt   = r_cmt_cnt;
    assign bus.ow_ovf       = r_ovf;
endmodule

// File: tb/tb_amber_ras.sv
// tb_amber_ras: queue-based stack model feeding a scoreboard, plus directed RET-prediction scenarios
module tb_amber_ras;
    import amber_ras_pkg::*;

    typedef struct {
        logic        v;
        logic [23:0] a;
        logic [3:0]  sc;
        logic [3:0]  cc;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          errs = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [23:0] ms[$];
    logic [23:0] mc[$];

    amber_ras_if bus ();
    amber_ras dut (.iw_clk(clk), .iw_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic sp, input logic spo, input logic [23:0] sa,
                        input logic cp, input logic cpo, input logic [23:0] ca,
                        input logic fl, input logic rn);
        exp_t e;
        exp_t g;
        logic ov;
        ov = 1'b0;
        rst_n = rn;
        bus.iw_spec_push = sp;
        bus.iw_spec_pop  = spo;
        bus.iw_spec_addr = sa;
        bus.iw_cmt_push  = cp;
        bus.iw_cmt_pop   = cpo;
        bus.iw_cmt_addr  = ca;
        bus.iw_flush     = fl;
        if (!rn) begin
            ms.delete();
            mc.delete();
        end else begin
            if (cpo && mc.size() > 0) void'(mc.pop_back());
            if (cp) begin
                if (mc.size() == RAS_DEPTH) void'(mc.pop_front());
                mc.push_back(ca);
            end
            if (fl) ms = mc;
            else begin
                if (spo && ms.size() > 0) void'(ms.pop_back());
                if (sp) begin
                    if (ms.size() == RAS_DEPTH) begin
                        void'(ms.pop_front());
                        ov = 1'b1;
                    end
                    ms.push_back(sa);
                end
            end
        end
        e.v = ms.size() != 0;
        e.a = 24'h0;
        if (e.v) e.a = ms[$];
        e.sc  = 4'(ms.size());
        e.cc  = 4'(mc.size());
        e.ovf = ov;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("sb_valid", 32'(bus.ow_top_valid), 32'(g.v));
        chk("sb_addr", 32'(bus.ow_top_addr), 32'(g.a));
        chk("sb_spec_cnt", 32'(bus.ow_spec_cnt), 32'(g.sc));
        chk("sb_cmt_cnt", 32'(bus.ow_cmt_cnt), 32'(g.cc));
        chk("sb_ovf", 32'(bus.ow_ovf), 32'(g.ovf));
    endtask

    task automatic spush(input logic [23:0] a);
        step(1'b1, 1'b0, a, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    endtask

    task automatic spop();
        step(1'b0, 1'b1, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    endtask

    initial begin
        step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
        chk("rst_valid", 32'(bus.ow_top_valid), 32'h0);
        chk("rst_addr", 32'(bus.ow_top_addr), 32'h0);

        spush(24'h00000C);
        spush(24'h000015);
        chk("t1_top", 32'(bus.ow_top_addr), 32'h15);
        chk("t1_cnt2", 32'(bus.ow_spec_cnt), 32'd2);
        spop();
        chk("t1_pop1", 32'(bus.ow_top_addr), 32'h0C);
        spop();
        chk("t1_empty_valid", 32'(bus.ow_top_valid), 32'h0);
        chk("t1_empty_addr", 32'(bus.ow_top_addr), 32'h0);

        for (int i = 0; i < 9; i++) begin
            spush(24'(32'h100 + i));
            chk("t2_ovf", 32'(bus.ow_ovf), 32'(i == 8));
        end
        chk("t2_full", 32'(bus.ow_spec_cnt), 32'd8);
        chk("t2_top", 32'(bus.ow_top_addr), 32'h108);
        for (int i = 0; i < 8; i++) begin
            spop();
            chk("t2_pop", 32'(bus.ow_top_addr), (i < 7) ? 32'h107 - 32'(i) : 32'h0);
        end
        spop();
        chk("t2_underflow", 32'(bus.ow_spec_cnt), 32'd0);

        step(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 24'h0C, 1'b0, 1'b1);
        spush(24'h0C);
        spush(24'h15);
        spush(24'h99);
        step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
        chk("t3_flush_top", 32'(bus.ow_top_addr), 32'h0C);
        chk("t3_flush_cnt", 32'(bus.ow_spec_cnt), 32'd1);
        spush(24'h99);
        step(1'b1, 1'b0, 24'h77, 1'b1, 1'b0, 24'h15, 1'b1, 1'b1);
        chk("t3_bypass_top", 32'(bus.ow_top_addr), 32'h15);
        chk("t3_bypass_cnt", 32'(bus.ow_spec_cnt), 32'd2);
        step(1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 24'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 24'h0, 1'b1, 1'b1);

        spush(24'h0A);
        step(1'b1, 1'b1, 24'h0B, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
        chk("t4_replace_top", 32'(bus.ow_top_addr), 32'h0B);
        chk("t4_replace_cnt", 32'(bus.ow_spec_cnt), 32'd1);
        spop();
        step(1'b1, 1'b1, 24'h0B, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
        chk("t4_empty_replace", 32'(bus.ow_spec_cnt), 32'd1);
        spop();

        spush(24'h31);
        spush(24'h32);
        spush(24'h33);
        step(1'b1, 1'b0, 24'h34, 1'b1, 1'b0, 24'h34, 1'b1, 1'b0);
        chk("t5_valid", 32'(bus.ow_top_valid), 32'h0);
        chk("t5_addr", 32'(bus.ow_top_addr), 32'h0);
        chk("t5_spec_cnt", 32'(bus.ow_spec_cnt), 32'd0);
        chk("t5_cmt_cnt", 32'(bus.ow_cmt_cnt), 32'd0);
        spop();
        chk("t5_pop_noop", 32'(bus.ow_spec_cnt), 32'd0);

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 24'h0C, 1'b1, 1'b0, 24'h0C, 1'b0, 1'b1);
            step(1'b1, 1'b0, 24'h15, 1'b1, 1'b0, 24'h15, 1'b0, 1'b1);
            chk("t6_top15", 32'(bus.ow_top_addr), 32'h15);
            step(1'b0, 1'b1, 24'h0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b1);
            chk("t6_top0c", 32'(bus.ow_top_addr), 32'h0C);
            step(1'b0, 1'b1, 24'h0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b1);
        end
        chk("t6_spec_cnt", 32'(bus.ow_spec_cnt), 32'd0);
        chk("t6_cmt_cnt", 32'(bus.ow_cmt_cnt), 32'd0);
        chk("t6_ovf", 32'(bus.ow_ovf), 32'h0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 24'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0), 24'($urandom),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 99) != 0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
